aes_key_exp_ctrl: RTL

- Sequencer for AES-128 key expansion on the team's 8-bit-datapath AES core.
- Loads a 128-bit cipher key and generates all 44 round-key words (11 round keys) into internal storage.
- Applies RotWord and Rcon internally. SubWord uses a shared external byte S-box, one byte per cycle.
- Provides a registered read port so the cipher round logic can fetch any round key.

---
 rtl/aes_key_exp_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_exp_ctrl.sv
// AES-128 key expansion sequencer: 44 round-key words, shared byte-serial S-box, registered read port.
// Optional AES_KEY_EXP_ZEROIZE_EN adds a zeroize input that wipes storage and aborts expansion.
module aes_key_exp_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter logic [7:0]  RCON_INIT  = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         sbox_req,
  output logic [7:0]   sbox_byte_out,
  input  logic [7:0]   sbox_byte_in,
`ifdef AES_KEY_EXP_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data,
  output logic         rk_rd_valid
);

  localparam int unsigned NUM_WORDS = 4 * (NUM_ROUNDS + 1);
  localparam int unsigned WIDX_W    = 6;

  typedef enum logic [2:0] {IDLE, LOAD, ROT, SUB, GEN, DONE} state_t;

  state_t              state, next_state;
  logic [31:0]         w [NUM_WORDS];
  logic [127:0]        key_q;
  logic [31:0]         temp;
  logic [7:0]          rcon;
  logic [3:0]          rnd;
  logic [1:0]          cnt;
  logic                clr;
  logic                wipe;
  logic                last_rnd;
  logic [WIDX_W-1:0]   widx;
  logic [31:0]         rot_word;
  logic [31:0]         gen_word;
  logic                busy_nxt, done_nxt, kv_nxt, req_nxt;
  logic [7:0]          sbyte_nxt;
  logic [1:0]          sel;

`ifdef AES_KEY_EXP_ZEROIZE_EN
  assign clr  = zeroize;
  assign wipe = rst | zeroize;
`else
  assign clr  = 1'b0;
  assign wipe = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign last_rnd = (rnd == 4'(NUM_ROUNDS));
  assign widx     = {rnd, cnt};

  // RotWord source w[4r-1] and the word produced by GEN step j=cnt
  always_comb begin
    rot_word = w[{rnd, 2'b00} - 6'd1];
    rot_word = {rot_word[23:0], rot_word[31:24]};
    if (cnt == 2'd0) gen_word = w[{rnd - 4'd1, cnt}] ^ temp ^ {rcon, 24'h0};
    else             gen_word = w[{rnd - 4'd1, cnt}] ^ w[widx - 6'd1];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    next_state = ROT;
      ROT:     next_state = SUB;
      SUB:     if (cnt == 2'd3) next_state = GEN;
      GEN:     if (cnt == 2'd3) next_state = last_rnd ? DONE : ROT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (clr) next_state = IDLE;
  end

  // Outputs are registered, so they are derived from the state being entered
  always_comb begin
    busy_nxt  = (next_state == LOAD) || (next_state == ROT) ||
                (next_state == SUB)  || (next_state == GEN);
    done_nxt  = (next_state == DONE);
    req_nxt   = (next_state == SUB);
    sbyte_nxt = 8'h00;
    sel       = cnt + 2'd1;
    kv_nxt    = keys_valid;
    if (next_state == SUB) begin
      if (state == ROT) begin
        sbyte_nxt = rot_word[31:24];
      end else begin
        case (sel)
          2'd0:    sbyte_nxt = temp[31:24];
          2'd1:    sbyte_nxt = temp[23:16];
          2'd2:    sbyte_nxt = temp[15:8];
          default: sbyte_nxt = temp[7:0];
        endcase
      end
    end
    if (state == IDLE && start) kv_nxt = 1'b0;
    if (next_state == DONE)     kv_nxt = 1'b1;
    if (clr)                    kv_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      keys_valid    <= 1'b0;
      sbox_req      <= 1'b0;
      sbox_byte_out <= 8'h00;
    end else begin
      busy          <= busy_nxt;
      done          <= done_nxt;
      keys_valid    <= kv_nxt;
      sbox_req      <= req_nxt;
      sbox_byte_out <= sbyte_nxt;
    end
  end

  // Sequencing registers: round, step counter, Rcon, temp word, captured key
  always_ff @(posedge clk) begin
    if (rst) begin
      rcon  <= RCON_INIT;
      rnd   <= 4'd0;
      cnt   <= 2'd0;
      temp  <= 32'h0;
      key_q <= 128'h0;
    end else if (clr) begin
      rcon  <= 8'h00;
      rnd   <= 4'd0;
      cnt   <= 2'd0;
      temp  <= 32'h0;
      key_q <= 128'h0;
    end else begin
      case (state)
        IDLE: if (start) key_q <= key_in;
        LOAD: begin
          rnd  <= 4'd1;
          rcon <= RCON_INIT;
        end
        ROT: begin
          temp <= rot_word;
          cnt  <= 2'd0;
        end
        SUB: begin
          case (cnt)
            2'd0:    temp[31:24] <= sbox_byte_in;
            2'd1:    temp[23:16] <= sbox_byte_in;
            2'd2:    temp[15:8]  <= sbox_byte_in;
            default: temp[7:0]   <= sbox_byte_in;
          endcase
          cnt <= cnt + 2'd1;
        end
        GEN: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3 && !last_rnd) begin
            rnd  <= rnd + 4'd1;
            rcon <= xtime(rcon);
          end
        end
        default: ;
      endcase
    end
  end

  // Round-key word storage; cleared only when zeroize support is built in
  always_ff @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < NUM_WORDS; i++) w[i] <= 32'h0;
    end else if (state == LOAD) begin
      w[0] <= key_q[127:96];
      w[1] <= key_q[95:64];
      w[2] <= key_q[63:32];
      w[3] <= key_q[31:0];
    end else if (state == GEN) begin
      w[widx] <= gen_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_rd_data  <= 128'h0;
      rk_rd_valid <= 1'b0;
    end else begin
      rk_rd_valid <= rk_rd_en;
      if (rk_rd_en) begin
        if (rk_rd_idx <= 4'(NUM_ROUNDS))
          rk_rd_data <= {w[{rk_rd_idx, 2'd0}], w[{rk_rd_idx, 2'd1}],
                         w[{rk_rd_idx, 2'd2}], w[{rk_rd_idx, 2'd3}]};
        else
          rk_rd_data <= 128'h0;
      end
    end
  end

endmodule
